cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Parametrised successor to the separate ALU and branch-ALU common data buses.
- Merges NUM_CH producer channels (ALU, branch ALU, future load/store, mul/div) onto one result bus.
- Buffers each channel in a small FIFO and grants with round-robin fairness.
- Sits between the execution units and the ROB / reservation-station snoop logic. Supports ROB back-pressure and a misprediction flush.

Parameters:
NUM_CH, 4, number of producer channels (>=2)
DEPTH, 2, entries per channel FIFO (power of two, >=2)
TAG_W, 4, ROB tag width (matches tagWidth)
DATA_W, 32, result data width (matches dataWidth)
CH_W, 2, width of channel index, equal to clog2(NUM_CH)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
flush  input  1  synchronous discard of all buffered and pending results
in_valid  input  NUM_CH  per-channel result valid
in_ready  output  NUM_CH  per-channel FIFO not full
in_tag  input  NUM_CH*TAG_W  per-channel ROB tag; channel i uses bits [i*TAG_W +: TAG_W]
in_data  input  NUM_CH*DATA_W  per-channel result data, packed as in_tag
cdb_valid  output  1  broadcast valid
cdb_tag  output  TAG_W  broadcast tag
cdb_data  output  DATA_W  broadcast data
cdb_src  output  CH_W  channel index of the current broadcast
cdb_ready  input  1  consumer (ROB) accepts the broadcast this cycle

Behaviour:
- Reset (rst low, asynchronous):
  - all FIFO counts and pointers cleared; round-robin pointer set to 0;
  - cdb_valid, cdb_tag, cdb_data, cdb_src all 0;
  - in_ready reads all ones once rst releases (all FIFOs empty).
- Per-channel FIFO:
  - count ranges 0..DEPTH; in_ready[i] = (count_i != DEPTH), computed from registered count only.
  - Push occurs when in_valid[i] && in_ready[i].
  - A full FIFO never accepts, even if it pops in the same cycle.
  - Read/write pointers wrap modulo DEPTH.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged; data order is preserved.
- Output register:
  - Holds one entry; "load" is allowed when cdb_valid==0 or cdb_ready==1.
  - On load, the arbiter selects the first non-empty FIFO scanning rr_ptr, rr_ptr+1, ... modulo NUM_CH.
  - The selected FIFO's head is popped into cdb_tag/cdb_data, cdb_src is set to its index, cdb_valid goes to 1, and rr_ptr is set to winner+1 (mod NUM_CH).
  - If all FIFOs are empty on a load cycle, cdb_valid goes to 0 and rr_ptr is unchanged.
- Stall: while cdb_valid && !cdb_ready, cdb_tag, cdb_data and cdb_src are held stable and no FIFO pops.
- Latency: a result pushed at edge k appears on the CDB after edge k+1 at the earliest. There is no combinational path from in_* to cdb_*.
- Throughput: one broadcast per cycle while cdb_ready stays high.
- Flush (synchronous, highest priority):
  - all FIFO counts go to 0, cdb_valid goes to 0, rr_ptr goes to 0;
  - pushes in the same cycle are dropped; cdb_ready is ignored that cycle.
- Asserting rst mid-stall or mid-burst discards all state immediately.
- Data is not modified; tags pass through unchanged. Ordering is guaranteed per channel only, not across channels.

Test Plan:
1. Reset then idle: rst low for 3 cycles, release -> in_ready=4'b1111, cdb_valid=0 for 5 idle cycles.
2. Single result: ch2 pushes tag=5, data=0xDEADBEEF at edge k, cdb_ready=1 -> after edge k+1: cdb_valid=1, tag=5, data=0xDEADBEEF, src=2; after edge k+2: cdb_valid=0.
3. Round-robin: all 4 channels push one entry in the same cycle, cdb_ready=1 -> broadcasts in src order 0,1,2,3 on consecutive cycles. Repeating the same stimulus then yields order 0,1,2,3 again (rr_ptr wrapped to 0).
4. Back-pressure and full:
   - cdb_ready=0; ch1 pushes 3 entries on consecutive cycles.
   - First entry moves to the output register, next two fill the FIFO; in_ready[1]=0 after the third push; a fourth in_valid is not accepted.
   - Raise cdb_ready -> tags emerge in push order, in_ready[1] returns to 1 one cycle after the first pop.
5. Flush: with 2 entries buffered and cdb_valid=1, assert flush together with a ch0 push -> next cycle cdb_valid=0, in_ready=4'b1111, and no broadcast of any prior or same-cycle entry.
6. Async reset mid-stall: cdb_valid=1, cdb_ready=0, drop rst between edges -> cdb_valid=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer channels and result-bus signals of the CDB arbiter
interface cdb_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int CH_W   = 2
);
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*TAG_W-1:0]  in_tag;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_data;
  logic [CH_W-1:0]          cdb_src;
  logic                     cdb_ready;

  modport master (
    output in_valid, in_tag, in_data, cdb_ready,
    input  in_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  in_valid, in_tag, in_data, cdb_ready,
    output in_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-channel result FIFOs merged round-robin onto one registered CDB
module cdb_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int CH_W   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = TAG_W + DATA_W;

  logic [ENT_W-1:0]  mem    [NUM_CH][DEPTH];
  logic [CNT_W-1:0]  count  [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   win;
  logic              found;
  logic              load;
  logic [NUM_CH-1:0] ready;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [ENT_W-1:0]  head;

  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [CH_W-1:0]   cdb_src_q;

  assign bus.in_ready  = ready;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_src   = cdb_src_q;

  // Scan downwards so the channel closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    load  = !cdb_valid_q || bus.cdb_ready;
    found = 1'b0;
    win   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (count[idx] != '0) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      ready[i] = (count[i] != CNT_W'(DEPTH));
      push[i]  = bus.in_valid[i] && ready[i] && !flush;
      pop[i]   = load && found && (win == CH_W'(i)) && !flush;
    end
    head = mem[win][rd_ptr[win]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= {bus.in_tag[i*TAG_W +: TAG_W], bus.in_data[i*DATA_W +: DATA_W]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr      <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr      <= '0;
      cdb_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
      if (load) begin
        if (found) begin
          cdb_valid_q <= 1'b1;
          {cdb_tag_q, cdb_data_q} <= head;
          cdb_src_q   <= win;
          rr_ptr      <= (win == CH_W'(NUM_CH - 1)) ? '0 : win + CH_W'(1);
        end else begin
          cdb_valid_q <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - queue-model bench for cdb_arbiter with directed and random traffic
module tb_cdb_arbiter;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 2;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int CH_W   = 2;
  localparam int ENT_W  = TAG_W + DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .DATA_W(DATA_W), .CH_W(CH_W)) bus ();

  cdb_arbiter #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .CH_W(CH_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  logic [ENT_W-1:0]  q [NUM_CH][$];
  logic              m_valid;
  logic [TAG_W-1:0]  m_tag;
  logic [DATA_W-1:0] m_data;
  int                m_src;
  int                m_rr;
  int                n_cmp = 0;
  int                n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) q[i].delete();
    m_valid = 1'b0;
    m_tag   = '0;
    m_data  = '0;
    m_src   = 0;
    m_rr    = 0;
  endtask

  function automatic logic [NUM_CH-1:0] model_ready();
    logic [NUM_CH-1:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i] = (q[i].size() < DEPTH);
    return r;
  endfunction

  // One clock edge worth of the specified behaviour, applied to the queues.
  task automatic model_step();
    logic [NUM_CH-1:0] rdy;
    int w;
    rdy = model_ready();
    if (flush) begin
      for (int i = 0; i < NUM_CH; i++) q[i].delete();
      m_valid = 1'b0;
      m_rr    = 0;
    end else begin
      if (!m_valid || bus.cdb_ready) begin
        w = -1;
        for (int k = 0; k < NUM_CH; k++) begin
          int c;
          c = (m_rr + k) % NUM_CH;
          if (w < 0 && q[c].size() > 0) w = c;
        end
        if (w >= 0) begin
          {m_tag, m_data} = q[w].pop_front();
          m_src   = w;
          m_valid = 1'b1;
          m_rr    = (w + 1) % NUM_CH;
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.in_valid[i] && rdy[i])
          q[i].push_back({bus.in_tag[i*TAG_W +: TAG_W], bus.in_data[i*DATA_W +: DATA_W]});
      end
    end
  endtask

  task automatic compare_all();
    check("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
    if (m_valid) begin
      check("cdb_tag",  64'(bus.cdb_tag),  64'(m_tag));
      check("cdb_data", 64'(bus.cdb_data), 64'(m_data));
      check("cdb_src",  64'(bus.cdb_src),  64'(m_src));
    end
    check("in_ready", 64'(bus.in_ready), 64'(model_ready()));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    bus.in_valid = '0;
    flush = 1'b0;
  endtask

  task automatic put(input int ch, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    bus.in_valid[ch] = 1'b1;
    bus.in_tag[ch*TAG_W +: TAG_W] = tag;
    bus.in_data[ch*DATA_W +: DATA_W] = data;
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_tag    = '0;
    bus.in_data   = '0;
    bus.cdb_ready = 1'b1;
    model_reset();

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.cdb_valid), 64'd0);
    check("rst_tag",   64'(bus.cdb_tag),   64'd0);
    check("rst_data",  64'(bus.cdb_data),  64'd0);
    check("rst_src",   64'(bus.cdb_src),   64'd0);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle_ready", 64'(bus.in_ready), 64'hf);
      check("idle_valid", 64'(bus.cdb_valid), 64'd0);
    end

    // Single result on channel 2
    put(2, 4'd5, 32'hDEADBEEF);
    tick();
    idle();
    tick();
    check("single_valid", 64'(bus.cdb_valid), 64'd1);
    check("single_tag",   64'(bus.cdb_tag),   64'd5);
    check("single_data",  64'(bus.cdb_data),  64'hDEADBEEF);
    check("single_src",   64'(bus.cdb_src),   64'd2);
    tick();
    check("single_done", 64'(bus.cdb_valid), 64'd0);

    // Round-robin from pointer 0, twice
    flush = 1'b1;
    tick();
    idle();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_CH; i++) put(i, 4'(8 + i), $urandom);
      tick();
      idle();
      for (int j = 0; j < NUM_CH; j++) begin
        tick();
        check("rr_valid", 64'(bus.cdb_valid), 64'd1);
        check("rr_src",   64'(bus.cdb_src),   64'(j));
      end
      tick();
    end

    // Back-pressure and full FIFO on channel 1
    bus.cdb_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      put(1, 4'(t), 32'(t * 100));
      tick();
    end
    check("full_ready1", 64'(bus.in_ready[1]), 64'd0);
    check("stall_tag",   64'(bus.cdb_tag),     64'd1);
    put(1, 4'd4, 32'd400);
    tick();
    check("full_still", 64'(bus.in_ready[1]), 64'd0);
    check("stall_hold", 64'(bus.cdb_tag),     64'd1);
    idle();
    bus.cdb_ready = 1'b1;
    tick();
    check("bp_tag2",   64'(bus.cdb_tag),     64'd2);
    check("bp_ready1", 64'(bus.in_ready[1]), 64'd1);
    tick();
    check("bp_tag3", 64'(bus.cdb_tag), 64'd3);
    tick();
    check("bp_drop4", 64'(bus.cdb_valid), 64'd0);

    // Flush with buffered entries and a same-cycle push
    bus.cdb_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      put(2, 4'(t + 10), $urandom);
      tick();
    end
    check("pre_flush_valid", 64'(bus.cdb_valid), 64'd1);
    idle();
    flush = 1'b1;
    put(0, 4'd7, 32'h1234);
    tick();
    check("flush_valid", 64'(bus.cdb_valid), 64'd0);
    check("flush_ready", 64'(bus.in_ready),  64'hf);
    idle();
    bus.cdb_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_flush_quiet", 64'(bus.cdb_valid), 64'd0);
    end

    // Asynchronous reset during a stall
    bus.cdb_ready = 1'b0;
    put(3, 4'd9, 32'h55);
    tick();
    idle();
    tick();
    check("stall_valid", 64'(bus.cdb_valid), 64'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_valid", 64'(bus.cdb_valid), 64'd0);
    check("async_ready", 64'(bus.in_ready),  64'hf);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // Random traffic: low then high consumer acceptance
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid = 4'($urandom);
      bus.in_tag   = 16'($urandom);
      for (int i = 0; i < NUM_CH; i++) bus.in_data[i*DATA_W +: DATA_W] = $urandom;
      bus.cdb_ready = (c < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      flush = ($urandom_range(0, 63) == 0);
      tick();
    end
    idle();
    bus.cdb_ready = 1'b1;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
